intersection_phase_ctrl: RTL and testbench

//  Parametrised two-road intersection signal controller: fixed-time cycle A-left, A-green, A-yellow,
//  all-red, B-left, B-green, B-yellow, all-red. Adds a built-in 1-tick prescaler, per-road countdown

---
 rtl/intersection_phase_ctrl_if.sv | 34 +++
 rtl/intersection_phase_ctrl.sv | 172 +++++++++++++++++
 tb/tb_intersection_phase_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/intersection_phase_ctrl_if.sv
// Intersection controller signal bundle: night-mode request in, lamp drives,
// countdown displays and debug phase code out.
interface intersection_phase_ctrl_if #(
  parameter int CNT_W = 7
);
  logic             night_mode;
  logic             left_turn_a;
  logic             green_a;
  logic             yellow_a;
  logic             red_a;
  logic             left_turn_b;
  logic             green_b;
  logic             yellow_b;
  logic             red_b;
  logic [CNT_W-1:0] countdown_a;
  logic [CNT_W-1:0] countdown_b;
  logic [3:0]       phase;

  // Controller side
  modport master (
    input  night_mode,
    output left_turn_a, green_a, yellow_a, red_a,
    output left_turn_b, green_b, yellow_b, red_b,
    output countdown_a, countdown_b, phase
  );

  // Lamp driver / display side
  modport slave (
    output night_mode,
    input  left_turn_a, green_a, yellow_a, red_a,
    input  left_turn_b, green_b, yellow_b, red_b,
    input  countdown_a, countdown_b, phase
  );
endinterface

// File: rtl/intersection_phase_ctrl.sv
// Fixed-time two-road intersection controller with tick prescaler,
// per-road countdown displays and flashing-yellow night mode.
module intersection_phase_ctrl #(
  parameter int CLK_DIV   = 50000000,
  parameter int CNT_W     = 7,
  parameter int T_LEFT_A  = 15,
  parameter int T_GREEN_A = 40,
  parameter int T_LEFT_B  = 15,
  parameter int T_GREEN_B = 30,
  parameter int T_YELLOW  = 5,
  parameter int T_ALLRED  = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  intersection_phase_ctrl_if.master     bus
);

  localparam int              PS_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    A_LEFT   = 4'd0,
    A_GREEN  = 4'd1,
    A_YELLOW = 4'd2,
    A_CLEAR  = 4'd3,
    B_LEFT   = 4'd4,
    B_GREEN  = 4'd5,
    B_YELLOW = 4'd6,
    B_CLEAR  = 4'd7,
    NIGHT    = 4'd8
  } state_t;

  logic [PS_W-1:0]  ps_cnt;
  logic             tick;
  state_t           state, state_n;
  logic [CNT_W-1:0] rem, rem_n;
  logic             flash, flash_n;
  // Set while in the all-red that follows night mode; that clearance hands
  // back to A_LEFT instead of B_LEFT.
  logic             resume, resume_n;

  // Timer reload value (duration minus one) on entering a state
  function automatic logic [CNT_W-1:0] dur_m1(state_t s);
    case (s)
      A_LEFT:            dur_m1 = CNT_W'(T_LEFT_A - 1);
      A_GREEN:           dur_m1 = CNT_W'(T_GREEN_A - 1);
      B_LEFT:            dur_m1 = CNT_W'(T_LEFT_B - 1);
      B_GREEN:           dur_m1 = CNT_W'(T_GREEN_B - 1);
      A_YELLOW, B_YELLOW: dur_m1 = CNT_W'(T_YELLOW - 1);
      A_CLEAR, B_CLEAR:  dur_m1 = CNT_W'(T_ALLRED - 1);
      default:           dur_m1 = '0;
    endcase
  endfunction

  // Ticks between the end of state s and the start of A's left-turn phase
  function automatic logic [CNT_W-1:0] wait_a(state_t s, logic res);
    case (s)
      A_CLEAR:  wait_a = res ? '0 : CNT_W'(T_LEFT_B + T_GREEN_B + T_YELLOW + T_ALLRED);
      B_LEFT:   wait_a = CNT_W'(T_GREEN_B + T_YELLOW + T_ALLRED);
      B_GREEN:  wait_a = CNT_W'(T_YELLOW + T_ALLRED);
      B_YELLOW: wait_a = CNT_W'(T_ALLRED);
      default:  wait_a = '0;
    endcase
  endfunction

  // Ticks between the end of state s and the start of B's left-turn phase
  function automatic logic [CNT_W-1:0] wait_b(state_t s, logic res);
    case (s)
      A_LEFT:   wait_b = CNT_W'(T_GREEN_A + T_YELLOW + T_ALLRED);
      A_GREEN:  wait_b = CNT_W'(T_YELLOW + T_ALLRED);
      A_YELLOW: wait_b = CNT_W'(T_ALLRED);
      A_CLEAR:  wait_b = res ? CNT_W'(T_LEFT_A + T_GREEN_A + T_YELLOW + T_ALLRED) : '0;
      B_CLEAR:  wait_b = CNT_W'(T_LEFT_A + T_GREEN_A + T_YELLOW + T_ALLRED);
      default:  wait_b = '0;
    endcase
  endfunction

  assign tick = (ps_cnt == PS_LAST);

  // Prescaler: one-clk tick every CLK_DIV clocks
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ps_cnt <= '0;
    else if (tick) ps_cnt <= '0;
    else ps_cnt <= ps_cnt + PS_W'(1);
  end

  // Phase state, timer, flash and resume registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= A_LEFT;
      rem    <= CNT_W'(T_LEFT_A - 1);
      flash  <= 1'b0;
      resume <= 1'b0;
    end else begin
      state  <= state_n;
      rem    <= rem_n;
      flash  <= flash_n;
      resume <= resume_n;
    end
  end

  // Next-state: timer countdown, fixed phase order, night entry/exit at clearances
  always_comb begin
    state_n  = state;
    rem_n    = rem;
    flash_n  = flash;
    resume_n = resume;
    if (tick) begin
      if (state == NIGHT) begin
        rem_n   = '0;
        flash_n = ~flash;
        if (!bus.night_mode) begin
          state_n  = A_CLEAR;
          rem_n    = CNT_W'(T_ALLRED - 1);
          flash_n  = 1'b0;
          resume_n = 1'b1;
        end
      end else if (rem != '0) begin
        rem_n = rem - CNT_W'(1);
      end else if ((state == A_CLEAR || state == B_CLEAR) && bus.night_mode) begin
        state_n  = NIGHT;
        rem_n    = '0;
        flash_n  = 1'b1;
        resume_n = 1'b0;
      end else begin
        case (state)
          A_LEFT:   state_n = A_GREEN;
          A_GREEN:  state_n = A_YELLOW;
          A_YELLOW: state_n = A_CLEAR;
          A_CLEAR:  state_n = resume ? A_LEFT : B_LEFT;
          B_LEFT:   state_n = B_GREEN;
          B_GREEN:  state_n = B_YELLOW;
          B_YELLOW: state_n = B_CLEAR;
          default:  state_n = A_LEFT;
        endcase
        rem_n    = dur_m1(state_n);
        resume_n = 1'b0;
      end
    end
  end

  // Moore lamp decode and countdown displays
  always_comb begin
    bus.left_turn_a = 1'b0;
    bus.green_a     = 1'b0;
    bus.yellow_a    = 1'b0;
    bus.red_a       = 1'b0;
    bus.left_turn_b = 1'b0;
    bus.green_b     = 1'b0;
    bus.yellow_b    = 1'b0;
    bus.red_b       = 1'b0;
    bus.phase       = state;
    bus.countdown_a = rem + CNT_W'(1) + wait_a(state, resume);
    bus.countdown_b = rem + CNT_W'(1) + wait_b(state, resume);
    case (state)
      A_LEFT:   begin bus.left_turn_a = 1'b1; bus.red_b = 1'b1; end
      A_GREEN:  begin bus.green_a     = 1'b1; bus.red_b = 1'b1; end
      A_YELLOW: begin bus.yellow_a    = 1'b1; bus.red_b = 1'b1; end
      B_LEFT:   begin bus.left_turn_b = 1'b1; bus.red_a = 1'b1; end
      B_GREEN:  begin bus.green_b     = 1'b1; bus.red_a = 1'b1; end
      B_YELLOW: begin bus.yellow_b    = 1'b1; bus.red_a = 1'b1; end
      NIGHT: begin
        bus.yellow_a    = flash;
        bus.yellow_b    = flash;
        bus.countdown_a = '0;
        bus.countdown_b = '0;
      end
      default:  begin bus.red_a = 1'b1; bus.red_b = 1'b1; end
    endcase
  end

endmodule

// File: tb/tb_intersection_phase_ctrl.sv
// Randomized bench for intersection_phase_ctrl: two instances (prescaled and
// tick-every-clock) checked against a phase-table reference model.
module tb_intersection_phase_ctrl;

  localparam int CNT_W = 5;
  localparam int TLA = 3, TGA = 4, TLB = 2, TGB = 3, TY = 2, TAR = 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic night = 1'b0;

  intersection_phase_ctrl_if #(.CNT_W(CNT_W)) bus0 ();
  intersection_phase_ctrl_if #(.CNT_W(CNT_W)) bus1 ();
  assign bus0.night_mode = night;
  assign bus1.night_mode = night;

  intersection_phase_ctrl #(
    .CLK_DIV(4), .CNT_W(CNT_W), .T_LEFT_A(TLA), .T_GREEN_A(TGA),
    .T_LEFT_B(TLB), .T_GREEN_B(TGB), .T_YELLOW(TY), .T_ALLRED(TAR)
  ) dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0));

  intersection_phase_ctrl #(
    .CLK_DIV(1), .CNT_W(CNT_W), .T_LEFT_A(TLA), .T_GREEN_A(TGA),
    .T_LEFT_B(TLB), .T_GREEN_B(TGB), .T_YELLOW(TY), .T_ALLRED(TAR)
  ) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // Reference model: phase index in the fixed cycle (8 = night), ticks left
  // in the phase including the current one, flash lamp, post-night flag.
  int m_ph[2], m_left[2], m_cnt[2];
  bit m_flash[2], m_res[2];

  function automatic int div_of(int k);
    return (k == 0) ? 4 : 1;
  endfunction

  function automatic int dur(int p);
    case (p)
      0: return TLA;
      1: return TGA;
      2: return TY;
      3: return TAR;
      4: return TLB;
      5: return TGB;
      6: return TY;
      7: return TAR;
      default: return 0;
    endcase
  endfunction

  function automatic int nxt(int p, bit res);
    if (p == 3 && res) return 0;
    return (p + 1) % 8;
  endfunction

  // Ticks until the given road's left-turn phase (target 0 or 4) / end of its active phase
  function automatic int exp_cd(int k, int target);
    int t, q;
    if (m_ph[k] == 8) return 0;
    if (m_ph[k] >= target && m_ph[k] <= target + 2) return m_left[k];
    t = m_left[k];
    q = nxt(m_ph[k], m_res[k]);
    for (int i = 0; i < 8 && q != target; i++) begin
      t += dur(q);
      q = nxt(q, 1'b0);
    end
    return t;
  endfunction

  // {left_a, green_a, yellow_a, red_a, left_b, green_b, yellow_b, red_b}
  function automatic int exp_lamps(int k);
    case (m_ph[k])
      0: return 8'b1000_0001;
      1: return 8'b0100_0001;
      2: return 8'b0010_0001;
      4: return 8'b0001_1000;
      5: return 8'b0001_0100;
      6: return 8'b0001_0010;
      8: return m_flash[k] ? 8'b0010_0010 : 8'b0000_0000;
      default: return 8'b0001_0001;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ph[k] = 0; m_left[k] = TLA; m_cnt[k] = 0; m_flash[k] = 0; m_res[k] = 0;
    end
  endtask

  task automatic model_tick(int k, bit nm);
    if (m_ph[k] == 8) begin
      m_flash[k] = ~m_flash[k];
      if (!nm) begin
        m_ph[k] = 3; m_left[k] = TAR; m_flash[k] = 0; m_res[k] = 1;
      end
    end else if (m_left[k] > 1) begin
      m_left[k]--;
    end else if ((m_ph[k] == 3 || m_ph[k] == 7) && nm) begin
      m_ph[k] = 8; m_left[k] = 0; m_flash[k] = 1; m_res[k] = 0;
    end else begin
      m_ph[k] = nxt(m_ph[k], m_res[k]);
      m_left[k] = dur(m_ph[k]);
      m_res[k] = 0;
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_reset();
    else begin
      for (int k = 0; k < 2; k++) begin
        if (m_cnt[k] == div_of(k) - 1) begin
          m_cnt[k] = 0;
          model_tick(k, night);
        end else m_cnt[k]++;
      end
    end
  end

  task automatic check_all();
    chk("d0.lamps", {bus0.left_turn_a, bus0.green_a, bus0.yellow_a, bus0.red_a,
                     bus0.left_turn_b, bus0.green_b, bus0.yellow_b, bus0.red_b}, exp_lamps(0));
    chk("d0.phase", bus0.phase, (m_ph[0] == 8) ? 8 : m_ph[0]);
    chk("d0.countdown_a", bus0.countdown_a, exp_cd(0, 0));
    chk("d0.countdown_b", bus0.countdown_b, exp_cd(0, 4));
    chk("d1.lamps", {bus1.left_turn_a, bus1.green_a, bus1.yellow_a, bus1.red_a,
                     bus1.left_turn_b, bus1.green_b, bus1.yellow_b, bus1.red_b}, exp_lamps(1));
    chk("d1.phase", bus1.phase, m_ph[1]);
    chk("d1.countdown_a", bus1.countdown_a, exp_cd(1, 0));
    chk("d1.countdown_b", bus1.countdown_b, exp_cd(1, 4));
  endtask

  initial begin
    int tog_range;
    bit rst_pending;
    tog_range = 150;
    rst_pending = 0;
    model_reset();
    // Reset state
    repeat (3) begin
      @(negedge clk);
      check_all();
    end
    reset_n = 1'b1;
    // One full fixed-time cycle with no night request
    repeat (100) begin
      @(negedge clk);
      check_all();
    end
    // Long night request raised mid-cycle, then released
    night = 1'b1;
    repeat (200) begin
      @(negedge clk);
      check_all();
    end
    night = 1'b0;
    repeat (100) begin
      @(negedge clk);
      check_all();
    end
    // Random night requests, fast and slow toggling, occasional resets
    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(negedge clk);
      check_all();
      if (rst_pending) begin
        reset_n = 1'b1;
        rst_pending = 0;
      end
      if (cyc % 250 == 0) tog_range = ($urandom_range(0, 1) == 0) ? 6 : 150;
      if ($urandom_range(0, tog_range - 1) == 0) night = ~night;
      if ($urandom_range(0, 599) == 0) begin
        reset_n = 1'b0;
        rst_pending = 1;
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
